// File: rtl/hazard_controller_pkg.sv
// Shared opcode/ALU-op constants and FSM state encoding for the pipeline
// interlock controller.
package hazard_controller_pkg;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00100;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_controller_detect.sv
// Combinational load-use detector: decodes which source registers the decode
// instruction reads and compares them against a load sitting in execute.
module hazard_detect
  import hazard_controller_pkg::*;
(
  input  logic [4:0] d_opcode,
  input  logic [4:0] d_readRegA,
  input  logic [4:0] d_readRegB,
  input  logic       x_valid,
  input  logic [4:0] x_opcode,
  input  logic [4:0] x_writeReg,
  output logic       load_use
);

  logic uses_a;
  logic uses_b;
  logic match_a;
  logic match_b;

  always_comb begin
    uses_a = d_opcode inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT};
    uses_b = d_opcode inside {OP_R, OP_SW, OP_BNE, OP_BLT, OP_JR};
  end

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign match_a  = uses_a && (x_writeReg == d_readRegA);
  assign match_b  = uses_b && (x_writeReg == d_readRegB);
  assign load_use = x_valid && (x_opcode == OP_LW) && (x_writeReg != 5'd0)
                    && (match_a || match_b);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline interlock controller: load-use stall, taken-branch flush, mult/div
// sequencing with a watchdog, and a saturating stall-cycle counter.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       d_opcode,
  input  logic [4:0]       d_readRegA,
  input  logic [4:0]       d_readRegB,
  input  logic             x_valid,
  input  logic [4:0]       x_opcode,
  input  logic [4:0]       x_aluop,
  input  logic [4:0]       x_writeReg,
  input  logic             x_branch_taken,
  input  logic             md_ready,
  output logic             stall_fd,
  output logic             bubble_dx,
  output logic             flush_fd,
  output logic             hold_x,
  output logic             md_start,
  output logic             md_done,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int               WAIT_W    = $clog2(MD_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MD_TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              is_md;
  logic              wd_expire;

  hazard_detect u_detect (
    .d_opcode   (d_opcode),
    .d_readRegA (d_readRegA),
    .d_readRegB (d_readRegB),
    .x_valid    (x_valid),
    .x_opcode   (x_opcode),
    .x_writeReg (x_writeReg),
    .load_use   (load_use)
  );

  assign is_md = x_valid && (x_opcode == OP_R)
                 && ((x_aluop == ALU_MUL) || (x_aluop == ALU_DIV));

  // wait_cnt holds the number of MD_WAIT cycles already spent, so the
  // MD_TIMEOUT-th waiting cycle is the one that sees LAST_WAIT
  assign wd_expire = (state == MD_WAIT) && !md_ready && (wait_cnt == LAST_WAIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (is_md) state_nxt = MD_WAIT;
      MD_WAIT: if (md_ready || wd_expire) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall_fd  = 1'b0;
    bubble_dx = 1'b0;
    flush_fd  = 1'b0;
    hold_x    = 1'b0;
    md_start  = 1'b0;
    md_done   = 1'b0;
    if (reset) begin
      unique case (state)
        RUN: begin
          if (is_md) begin
            md_start = 1'b1;
            stall_fd = 1'b1;
            hold_x   = 1'b1;
          end else if (x_branch_taken) begin
            flush_fd  = 1'b1;
            bubble_dx = 1'b1;
          end else if (load_use) begin
            stall_fd  = 1'b1;
            bubble_dx = 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_ready) begin
            md_done = 1'b1;
          end else begin
            stall_fd = 1'b1;
            hold_x   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)               wait_cnt <= '0;
    else if (state == RUN)    wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         md_timeout <= 1'b0;
    else if (wd_expire) md_timeout <= 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                              stall_count <= '0;
    else if (stall_fd && (stall_count != '1)) stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench: two controller instances (default and small
// timeout/counter) driven by shared directed + random stimulus.
module tb_hazard_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] d_opcode, d_readRegA, d_readRegB;
  logic       x_valid;
  logic [4:0] x_opcode, x_aluop, x_writeReg;
  logic       x_branch_taken, md_ready;

  logic        stall_a, bubble_a, flush_a, hold_a, start_a, done_a, to_a;
  logic [15:0] cnt_a;
  logic        stall_b, bubble_b, flush_b, hold_b, start_b, done_b, to_b;
  logic [2:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  // instance 0 = (40, 16 bits), instance 1 = (4, 3 bits)
  int TMO[2]  = '{40, 4};
  int CMAX[2] = '{65535, 7};

  bit m_busy[2];
  int m_wait[2];
  bit m_to[2];
  int m_cnt[2];
  bit e_stall[2], e_bubble[2], e_flush[2], e_hold[2], e_start[2], e_done[2];

  logic [4:0] ops[8] = '{5'd0, 5'd8, 5'd7, 5'd5, 5'd2, 5'd6, 5'd4, 5'd31};

  hazard_controller #(.MD_TIMEOUT(40), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .d_opcode(d_opcode), .d_readRegA(d_readRegA),
    .d_readRegB(d_readRegB), .x_valid(x_valid), .x_opcode(x_opcode), .x_aluop(x_aluop),
    .x_writeReg(x_writeReg), .x_branch_taken(x_branch_taken), .md_ready(md_ready),
    .stall_fd(stall_a), .bubble_dx(bubble_a), .flush_fd(flush_a), .hold_x(hold_a),
    .md_start(start_a), .md_done(done_a), .md_timeout(to_a), .stall_count(cnt_a)
  );

  hazard_controller #(.MD_TIMEOUT(4), .CNT_W(3)) dut_b (
    .clock(clock), .reset(reset), .d_opcode(d_opcode), .d_readRegA(d_readRegA),
    .d_readRegB(d_readRegB), .x_valid(x_valid), .x_opcode(x_opcode), .x_aluop(x_aluop),
    .x_writeReg(x_writeReg), .x_branch_taken(x_branch_taken), .md_ready(md_ready),
    .stall_fd(stall_b), .bubble_dx(bubble_b), .flush_fd(flush_b), .hold_x(hold_b),
    .md_start(start_b), .md_done(done_b), .md_timeout(to_b), .stall_count(cnt_b)
  );

  always #5 clock = ~clock;

  function automatic bit reads_a(input logic [4:0] op);
    return (op == 5'd0) || (op == 5'd5) || (op == 5'd8) || (op == 5'd7)
        || (op == 5'd2) || (op == 5'd6);
  endfunction

  function automatic bit reads_b(input logic [4:0] op);
    return (op == 5'd0) || (op == 5'd7) || (op == 5'd2) || (op == 5'd6) || (op == 5'd4);
  endfunction

  function automatic bit x_is_muldiv();
    return x_valid && (x_opcode == 5'd0) && ((x_aluop == 5'd6) || (x_aluop == 5'd7));
  endfunction

  function automatic bit lw_conflict();
    if (!x_valid || x_opcode != 5'd8 || x_writeReg == 5'd0) return 1'b0;
    return (reads_a(d_opcode) && x_writeReg == d_readRegA)
        || (reads_b(d_opcode) && x_writeReg == d_readRegB);
  endfunction

  task automatic model_clear(input int i);
    m_busy[i] = 1'b0;
    m_wait[i] = 0;
    m_to[i]   = 1'b0;
    m_cnt[i]  = 0;
  endtask

  task automatic model_eval(input int i);
    e_stall[i] = 0; e_bubble[i] = 0; e_flush[i] = 0;
    e_hold[i]  = 0; e_start[i]  = 0; e_done[i]  = 0;
    if (reset) begin
      if (m_busy[i]) begin
        // unit busy: front end frozen until the result arrives
        e_done[i]  = md_ready;
        e_stall[i] = !md_ready;
        e_hold[i]  = !md_ready;
      end else if (x_is_muldiv()) begin
        e_start[i] = 1; e_stall[i] = 1; e_hold[i] = 1;
      end else if (x_branch_taken) begin
        e_flush[i] = 1; e_bubble[i] = 1;
      end else if (lw_conflict()) begin
        e_stall[i] = 1; e_bubble[i] = 1;
      end
    end
  endtask

  task automatic model_update(input int i);
    if (!reset) begin
      model_clear(i);
    end else begin
      if (e_stall[i] && m_cnt[i] < CMAX[i]) m_cnt[i] = m_cnt[i] + 1;
      if (!m_busy[i]) begin
        if (x_is_muldiv()) begin
          m_busy[i] = 1;
          m_wait[i] = 0;
        end
      end else if (md_ready) begin
        m_busy[i] = 0;
      end else begin
        m_wait[i] = m_wait[i] + 1;
        if (m_wait[i] >= TMO[i]) begin
          m_busy[i] = 0;
          m_to[i]   = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a.stall_fd",    stall_a,  e_stall[0]);
    chk("a.bubble_dx",   bubble_a, e_bubble[0]);
    chk("a.flush_fd",    flush_a,  e_flush[0]);
    chk("a.hold_x",      hold_a,   e_hold[0]);
    chk("a.md_start",    start_a,  e_start[0]);
    chk("a.md_done",     done_a,   e_done[0]);
    chk("a.md_timeout",  to_a,     m_to[0]);
    chk("a.stall_count", cnt_a,    m_cnt[0]);
    chk("b.stall_fd",    stall_b,  e_stall[1]);
    chk("b.bubble_dx",   bubble_b, e_bubble[1]);
    chk("b.flush_fd",    flush_b,  e_flush[1]);
    chk("b.hold_x",      hold_b,   e_hold[1]);
    chk("b.md_start",    start_b,  e_start[1]);
    chk("b.md_done",     done_b,   e_done[1]);
    chk("b.md_timeout",  to_b,     m_to[1]);
    chk("b.stall_count", cnt_b,    m_cnt[1]);
  endtask

  // inputs are set just after a falling edge; check, then advance one cycle
  task automatic step();
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!reset) model_clear(i);
      model_eval(i);
    end
    check_all();
    @(posedge clock);
    for (int i = 0; i < 2; i++) model_update(i);
    @(negedge clock);
  endtask

  task automatic set_idle();
    d_opcode = 5'd0; d_readRegA = 5'd0; d_readRegB = 5'd0;
    x_valid = 1'b0; x_opcode = 5'd0; x_aluop = 5'd0; x_writeReg = 5'd0;
    x_branch_taken = 1'b0; md_ready = 1'b0;
  endtask

  task automatic issue_md(input logic [4:0] aluop);
    x_valid = 1'b1; x_opcode = 5'd0; x_aluop = aluop; x_writeReg = 5'd9;
  endtask

  initial begin
    model_clear(0);
    model_clear(1);
    set_idle();
    step();
    step();
    reset = 1'b1;

    // load-use on rs: single-cycle stall + bubble
    x_valid = 1'b1; x_opcode = 5'd8; x_writeReg = 5'd3;
    d_opcode = 5'd0; d_readRegA = 5'd3; d_readRegB = 5'd5;
    step();
    set_idle();
    step();
    chk("lu.count_after", cnt_a, 32'd1);

    // load into r0 never stalls
    x_valid = 1'b1; x_opcode = 5'd8; x_writeReg = 5'd0;
    d_opcode = 5'd0; d_readRegA = 5'd0; d_readRegB = 5'd0;
    step();

    // taken branch overrides a matching load-use
    x_writeReg = 5'd3; d_readRegA = 5'd3; x_branch_taken = 1'b1;
    step();
    set_idle();
    step();
    chk("br.count_unchanged", cnt_a, 32'd1);

    // mul with result after five cycles
    issue_md(5'd6);
    step();
    for (int k = 0; k < 4; k++) step();
    md_ready = 1'b1;
    step();
    set_idle();
    step();
    chk("mul.count_after", cnt_a, 32'd6);
    for (int k = 0; k < 6; k++) step();

    // asynchronous reset in the middle of a wait
    issue_md(5'd7);
    step();
    x_valid = 1'b0;
    step();
    step();
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      model_clear(i);
      model_eval(i);
    end
    check_all();
    chk("rst.async_stall", stall_a, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    md_ready = 1'b1;
    step();
    md_ready = 1'b0;

    // watchdog with no ready ever arriving (instance b times out after 4)
    issue_md(5'd7);
    step();
    x_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("wd.before_expire", to_b, 32'd0);
    step();
    chk("wd.expired", to_b, 32'd1);
    md_ready = 1'b1;
    step();
    md_ready = 1'b0;
    step();
    chk("wd.sticky_b", to_b, 32'd1);
    chk("wd.none_a", to_a, 32'd0);

    // continuous stall saturates the 3-bit counter
    x_valid = 1'b1; x_opcode = 5'd8; x_writeReg = 5'd4;
    d_opcode = 5'd7; d_readRegA = 5'd1; d_readRegB = 5'd4;
    for (int k = 0; k < 10; k++) step();
    chk("sat.count_b", cnt_b, 32'd7);
    set_idle();
    step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      reset          = ($urandom_range(0, 80) != 0);
      x_valid        = ($urandom_range(0, 3) != 0);
      x_opcode       = ops[$urandom_range(0, 7)];
      x_aluop        = ($urandom_range(0, 5) == 0) ? 5'(5'd6 + 5'($urandom_range(0, 1)))
                                                    : 5'($urandom);
      x_writeReg     = 5'($urandom_range(0, 3));
      d_opcode       = ops[$urandom_range(0, 7)];
      d_readRegA     = 5'($urandom_range(0, 3));
      d_readRegB     = 5'($urandom_range(0, 3));
      x_branch_taken = ($urandom_range(0, 7) == 0);
      md_ready       = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
